level_cal_ctrl: RTL and testbench

//  Calibration/measurement sequencer behind the button debouncer. Consumes debounced one-shot

---
 rtl/level_cal_ctrl_if.sv | 30 +++
 rtl/level_cal_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_level_cal_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/level_cal_ctrl_if.sv
// Command/sample/result bundle for the level calibration sequencer.
// Commands and sample_valid are single-cycle pulses; there is no back-pressure.
interface level_cal_ctrl_if #(
    parameter int W = 12
);
    logic         tick_1kHz;
    logic         clear_cmd;
    logic         saveH_cmd;
    logic         saveL_cmd;
    logic [W-1:0] sample;
    logic         sample_valid;
    logic [W-1:0] cal_low;
    logic [W-1:0] cal_high;
    logic         cal_ok;
    logic         err;
    logic         busy;
    logic [6:0]   level_pct;
    logic         level_valid;
    logic [1:0]   state_dbg;

    modport master (
        output tick_1kHz, clear_cmd, saveH_cmd, saveL_cmd, sample, sample_valid,
        input  cal_low, cal_high, cal_ok, err, busy, level_pct, level_valid, state_dbg
    );

    modport slave (
        input  tick_1kHz, clear_cmd, saveH_cmd, saveL_cmd, sample, sample_valid,
        output cal_low, cal_high, cal_ok, err, busy, level_pct, level_valid, state_dbg
    );
endinterface

// File: rtl/level_cal_ctrl.sv
// Calibration/measurement sequencer: averages low/high capture points, validates the span
// and converts samples to a 0..100 percent level with a 7-step restoring divider.
module level_cal_ctrl #(
    parameter int W          = 12,
    parameter int AVG_LOG2   = 2,
    parameter int TIMEOUT_MS = 50,
    parameter int MIN_SPAN   = 16
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    level_cal_ctrl_if.slave   bus
);
    localparam int AW   = W + AVG_LOG2;
    localparam int DW   = W + 7;
    localparam int MS_W = $clog2(TIMEOUT_MS + 1);
    localparam logic [MS_W-1:0]     MS_LAST  = MS_W'(TIMEOUT_MS - 1);
    localparam logic [AVG_LOG2:0]   CNT_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CAPT  = 2'd1,
        S_CHECK = 2'd2,
        S_CALC  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [W-1:0]        r_cal_low;
    logic [W-1:0]        r_cal_high;
    logic                r_hi_set;
    logic                r_lo_set;
    logic                r_cal_ok;
    logic                r_err;
    logic                r_pend_vld;
    logic                r_pend_hi;
    logic                r_tgt_hi;
    logic [AW-1:0]       r_acc;
    logic [AVG_LOG2:0]   r_cnt;
    logic [MS_W-1:0]     r_ms;
    logic [W-1:0]        r_n;
    logic [W-1:0]        r_d;
    logic [DW-1:0]       r_rem;
    logic [DW-1:0]       r_dsh;
    logic [6:0]          r_q;
    logic [3:0]          r_step;
    logic [6:0]          r_pct;
    logic                r_lvl_valid;

    logic                w_one;
    logic                w_both;
    logic                w_start_capt;
    logic                w_start_hi;
    logic                w_pend_load;
    logic                w_pend_clr;
    logic                w_err_set;
    logic                w_capt_add;
    logic                w_capt_done;
    logic                w_start_calc;
    logic                w_do_check;
    logic                w_calc_load;
    logic                w_span_ok;
    logic [AW-1:0]       w_acc_sum;
    logic [W-1:0]        w_avg;
    logic [W-1:0]        w_clamp;
    logic [DW-1:0]       w_n_ext;
    logic [DW-1:0]       w_n100;

    assign w_one     = bus.saveH_cmd ^ bus.saveL_cmd;
    assign w_both    = bus.saveH_cmd & bus.saveL_cmd;
    assign w_acc_sum = r_acc + AW'(bus.sample);
    assign w_avg     = W'(w_acc_sum >> AVG_LOG2);
    assign w_span_ok = ({1'b0, r_cal_high} >= ({1'b0, r_cal_low} + (W + 1)'(MIN_SPAN)));
    assign w_clamp   = (bus.sample < r_cal_low)  ? r_cal_low  :
                       (bus.sample > r_cal_high) ? r_cal_high : bus.sample;
    // n*100 built from shifts so the multiply stays adder-only
    assign w_n_ext   = DW'(r_n);
    assign w_n100    = (w_n_ext << 6) + (w_n_ext << 5) + (w_n_ext << 2);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_capt = 1'b0;
        w_start_hi   = 1'b0;
        w_pend_load  = 1'b0;
        w_pend_clr   = 1'b0;
        w_err_set    = 1'b0;
        w_capt_add   = 1'b0;
        w_capt_done  = 1'b0;
        w_start_calc = 1'b0;
        w_do_check   = 1'b0;
        w_calc_load  = 1'b0;
        if (bus.clear_cmd) begin
            w_state_nxt = S_IDLE;
        end else begin
            w_err_set = w_both;
            case (r_state)
                S_IDLE: begin
                    if (r_pend_vld) begin
                        w_start_capt = 1'b1;
                        w_start_hi   = r_pend_hi;
                        w_pend_clr   = 1'b1;
                        w_pend_load  = w_one;
                        w_state_nxt  = S_CAPT;
                    end else if (w_one) begin
                        w_start_capt = 1'b1;
                        w_start_hi   = bus.saveH_cmd;
                        w_state_nxt  = S_CAPT;
                    end else if (!w_both && r_cal_ok && bus.sample_valid) begin
                        w_start_calc = 1'b1;
                        w_state_nxt  = S_CALC;
                    end
                end
                S_CAPT: begin
                    w_pend_load = w_one;
                    if (bus.sample_valid) begin
                        w_capt_add = 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            w_capt_done = 1'b1;
                            w_state_nxt = S_CHECK;
                        end
                    end
                    // a sample completing the capture wins over a same-cycle timeout
                    if (bus.tick_1kHz && !w_capt_done && (r_ms == MS_LAST)) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_CHECK: begin
                    w_pend_load = w_one;
                    w_do_check  = 1'b1;
                    if (r_hi_set && r_lo_set && !w_span_ok) begin
                        w_err_set = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
                S_CALC: begin
                    w_pend_load = w_one;
                    if (r_step == 4'd8) begin
                        w_calc_load = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_cal_low   <= '0;
            r_cal_high  <= '0;
            r_hi_set    <= 1'b0;
            r_lo_set    <= 1'b0;
            r_cal_ok    <= 1'b0;
            r_err       <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_hi   <= 1'b0;
            r_tgt_hi    <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ms        <= '0;
            r_n         <= '0;
            r_d         <= '0;
            r_rem       <= '0;
            r_dsh       <= '0;
            r_q         <= '0;
            r_step      <= '0;
            r_pct       <= '0;
            r_lvl_valid <= 1'b0;
        end else begin
            r_lvl_valid <= 1'b0;
            if (bus.clear_cmd) begin
                r_cal_low  <= '0;
                r_cal_high <= '0;
                r_hi_set   <= 1'b0;
                r_lo_set   <= 1'b0;
                r_cal_ok   <= 1'b0;
                r_err      <= 1'b0;
                r_pend_vld <= 1'b0;
            end else begin
                if (w_err_set) begin
                    r_err <= 1'b1;
                end
                if (w_pend_load) begin
                    r_pend_vld <= 1'b1;
                    r_pend_hi  <= bus.saveH_cmd;
                end else if (w_pend_clr) begin
                    r_pend_vld <= 1'b0;
                end
                if (w_start_capt) begin
                    r_tgt_hi <= w_start_hi;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_ms     <= '0;
                end
                if (w_capt_add) begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
                if ((r_state == S_CAPT) && bus.tick_1kHz) begin
                    r_ms <= r_ms + 1'b1;
                end
                if (w_capt_done) begin
                    if (r_tgt_hi) begin
                        r_cal_high <= w_avg;
                        r_hi_set   <= 1'b1;
                    end else begin
                        r_cal_low <= w_avg;
                        r_lo_set  <= 1'b1;
                    end
                end
                if (w_do_check) begin
                    r_cal_ok <= r_hi_set && r_lo_set && w_span_ok;
                end
                if (w_start_calc) begin
                    r_n    <= w_clamp - r_cal_low;
                    r_d    <= r_cal_high - r_cal_low;
                    r_step <= '0;
                end
                if (r_state == S_CALC) begin
                    r_step <= r_step + 1'b1;
                    if (r_step == 4'd0) begin
                        r_rem <= w_n100;
                        r_dsh <= DW'(r_d) << 6;
                        r_q   <= '0;
                    end else if (r_step <= 4'd7) begin
                        // quotient fits in 7 bits because n <= d
                        if (r_rem >= r_dsh) begin
                            r_rem <= r_rem - r_dsh;
                            r_q   <= {r_q[5:0], 1'b1};
                        end else begin
                            r_q <= {r_q[5:0], 1'b0};
                        end
                        r_dsh <= r_dsh >> 1;
                    end
                end
                if (w_calc_load) begin
                    r_pct       <= r_q;
                    r_lvl_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.cal_low     = r_cal_low;
    assign bus.cal_high    = r_cal_high;
    assign bus.cal_ok      = r_cal_ok;
    assign bus.err         = r_err;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.level_pct   = r_pct;
    assign bus.level_valid = r_lvl_valid;
    assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_level_cal_ctrl.sv
// Bench for level_cal_ctrl: directed command/sample sequences against a percentage model.
module tb_level_cal_ctrl;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    level_cal_ctrl_if #(.W(W)) bus();

    level_cal_ctrl #(.W(W), .AVG_LOG2(2), .TIMEOUT_MS(50), .MIN_SPAN(16)) dut (
        .clk_100MHz (clk),
        .reset      (rst),
        .bus        (bus)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    int m_lo = 0, m_hi = 0, m_pct = 0;
    bit m_lo_set = 0, m_hi_set = 0, m_ok = 0, m_err = 0;
    bit chk_en = 0;

    logic [6:0] exp_q[$];
    int         exp_t_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int mdl_level(input int s, input int lo, input int hi);
        int c;
        c = (s < lo) ? lo : ((s > hi) ? hi : s);
        return ((c - lo) * 100) / (hi - lo);
    endfunction

    task automatic mdl_store(input bit hi, input int avg);
        if (hi) begin m_hi = avg; m_hi_set = 1; end
        else    begin m_lo = avg; m_lo_set = 1; end
        if (m_hi_set && m_lo_set) begin
            m_ok = (m_hi >= m_lo + 16);
            if (!m_ok) m_err = 1;
        end else begin
            m_ok = 0;
        end
    endtask

    // per-cycle compare against the model, sampled just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                if (bus.level_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_level_valid", bus.level_valid, 0);
                    end else begin
                        check("level_pct_value", bus.level_pct, exp_q[0]);
                        check("level_latency", cyc, exp_t_q[0]);
                        m_pct = exp_q.pop_front();
                        void'(exp_t_q.pop_front());
                    end
                end else if (exp_t_q.size() > 0 && cyc > exp_t_q[0]) begin
                    check("level_valid_missing", bus.level_valid, 1);
                    void'(exp_q.pop_front());
                    void'(exp_t_q.pop_front());
                end
                if (chk_en) begin
                    check("cal_low", bus.cal_low, m_lo);
                    check("cal_high", bus.cal_high, m_hi);
                    check("cal_ok", bus.cal_ok, m_ok);
                    check("err", bus.err, m_err);
                    check("level_pct_held", bus.level_pct, m_pct);
                end
            end
        end
    end

    task automatic cmd(input bit h, input bit l, input bit c);
        @(negedge clk);
        bus.saveH_cmd = h;
        bus.saveL_cmd = l;
        bus.clear_cmd = c;
        @(negedge clk);
        bus.saveH_cmd = 0;
        bus.saveL_cmd = 0;
        bus.clear_cmd = 0;
    endtask

    task automatic do_capture(input bit hi, input int s0, input int s1, input int s2, input int s3);
        int s[4];
        s = '{s0, s1, s2, s3};
        chk_en = 0;
        cmd(hi, !hi, 0);
        check("capt_busy", bus.busy, 1);
        for (int i = 0; i < 4; i++) begin
            bus.sample       = s[i][W-1:0];
            bus.sample_valid = 1;
            @(negedge clk);
        end
        bus.sample_valid = 0;
        @(negedge clk);
        check("capt_back_idle", bus.busy, 0);
        mdl_store(hi, (s0 + s1 + s2 + s3) / 4);
        chk_en = 1;
    endtask

    task automatic measure(input int s);
        @(negedge clk);
        bus.sample       = s[W-1:0];
        bus.sample_valid = 1;
        exp_q.push_back(7'(mdl_level(s, m_lo, m_hi)));
        exp_t_q.push_back(cyc + 10);
        @(negedge clk);
        bus.sample_valid = 0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 40 && bus.busy; k++) @(negedge clk);
        if (k == 40) check("busy_stuck", bus.busy, 0);
        @(negedge clk);
    endtask

    task automatic clear_all();
        chk_en = 0;
        cmd(0, 0, 1);
        m_lo = 0; m_hi = 0; m_lo_set = 0; m_hi_set = 0; m_ok = 0; m_err = 0;
        check("clear_cal_low", bus.cal_low, 0);
        check("clear_cal_high", bus.cal_high, 0);
        check("clear_err", bus.err, 0);
        check("clear_busy", bus.busy, 0);
        chk_en = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.tick_1kHz = 0; bus.clear_cmd = 0; bus.saveH_cmd = 0; bus.saveL_cmd = 0;
        bus.sample = '0; bus.sample_valid = 0;
        repeat (3) @(negedge clk);
        check("rst_cal_low", bus.cal_low, 0);
        check("rst_cal_high", bus.cal_high, 0);
        check("rst_cal_ok", bus.cal_ok, 0);
        check("rst_err", bus.err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_level_pct", bus.level_pct, 0);
        check("rst_level_valid", bus.level_valid, 0);
        check("rst_state", bus.state_dbg, 0);
        rst = 0;
        chk_en = 1;

        do_capture(0, 100, 102, 98, 100);
        check("lit_cal_low_100", bus.cal_low, 100);
        check("lit_ok_one_point", bus.cal_ok, 0);
        do_capture(1, 4000, 4000, 4000, 4000);
        check("lit_cal_high_4000", bus.cal_high, 4000);
        check("lit_ok_span", bus.cal_ok, 1);
        check("lit_err_clean", bus.err, 0);

        measure(2050); wait_idle(); check("lit_pct_2050", bus.level_pct, 50);
        measure(50);   wait_idle(); check("lit_pct_50", bus.level_pct, 0);
        measure(4095); wait_idle(); check("lit_pct_4095", bus.level_pct, 100);
        measure(1000); wait_idle(); check("lit_pct_1000", bus.level_pct, 23);
        measure(3999); wait_idle(); check("lit_pct_3999", bus.level_pct, 99);
        measure(100);  wait_idle();

        // a second sample while the divider runs must be dropped
        measure(2050);
        @(negedge clk);
        bus.sample = 12'd1000; bus.sample_valid = 1;
        @(negedge clk);
        bus.sample_valid = 0;
        wait_idle();
        repeat (12) @(negedge clk);
        check("lit_pct_drop", bus.level_pct, 50);

        // capture timeout
        chk_en = 0;
        cmd(1, 0, 0);
        for (int t = 0; t < 50; t++) begin
            if (t == 49) check("busy_before_last_tick", bus.busy, 1);
            @(negedge clk); bus.tick_1kHz = 1;
            @(negedge clk); bus.tick_1kHz = 0;
        end
        check("timeout_busy", bus.busy, 0);
        check("timeout_err", bus.err, 1);
        check("timeout_cal_high", bus.cal_high, 4000);
        m_err = 1;
        chk_en = 1;
        clear_all();

        do_capture(0, 1000, 1000, 1000, 1000);
        do_capture(1, 1008, 1010, 1012, 1010);
        check("lit_narrow_err", bus.err, 1);
        check("lit_narrow_ok", bus.cal_ok, 0);
        clear_all();

        // command arriving during CALC waits for IDLE; clear drops a pending command
        do_capture(0, 100, 100, 100, 100);
        do_capture(1, 4000, 4000, 4000, 4000);
        measure(2050);
        repeat (3) @(negedge clk);
        bus.saveH_cmd = 1;
        @(negedge clk);
        bus.saveH_cmd = 0;
        for (k = 0; k < 20 && !bus.level_valid; k++) @(negedge clk);
        check("pend_lv_seen", bus.level_valid, 1);
        check("pend_idle_at_lv", bus.busy, 0);
        @(negedge clk);
        check("pend_capt_busy", bus.busy, 1);
        check("pend_capt_state", bus.state_dbg, 1);
        cmd(0, 1, 0);
        clear_all();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_pending_after_clear", bus.busy, 0);
        end
        check("lit_pct_held_clear", bus.level_pct, 50);

        // simultaneous saveH + saveL
        chk_en = 0;
        cmd(1, 1, 0);
        check("both_err", bus.err, 1);
        check("both_busy", bus.busy, 0);
        m_err = 1;
        @(negedge clk);
        check("both_stay_idle", bus.busy, 0);
        chk_en = 1;

        // asynchronous reset in the middle of a divide
        do_capture(0, 100, 100, 100, 100);
        do_capture(1, 4000, 4000, 4000, 4000);
        measure(1000);
        repeat (4) @(negedge clk);
        check("mid_div_busy", bus.busy, 1);
        chk_en = 0;
        exp_q.delete();
        exp_t_q.delete();
        rst = 1;
        #1;
        check("arst_cal_low", bus.cal_low, 0);
        check("arst_cal_high", bus.cal_high, 0);
        check("arst_cal_ok", bus.cal_ok, 0);
        check("arst_err", bus.err, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_level_pct", bus.level_pct, 0);
        check("arst_level_valid", bus.level_valid, 0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
